// File: rtl/accel_pkg.sv
// accel_pkg: types and defaults shared by the accelerator dispatch slice.
//   op_t      - which engine an accepted request targets
//   state_t   - dispatcher FSM states
//   opMask    - one-hot {H,E,D} select vector for an op
//   multiHot  - true when more than one bit of a 3-bit vector is set
package accel_pkg;

  localparam int DEF_IDX_W   = 11;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_H,
    OP_E,
    OP_D
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DONE,
    REARM
  } state_t;

  // Bit 2 = hash, bit 1 = encrypt, bit 0 = decrypt.
  function automatic logic [2:0] opMask(input op_t op);
    case (op)
      OP_H:    return 3'b100;
      OP_E:    return 3'b010;
      OP_D:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic multiHot(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'b000;
  endfunction

endpackage

// File: rtl/accel_dispatch_if.sv
// accel_dispatch_if: CPU side-channel request/done signals plus the
// start/finish/index signals toward the three crypto engines.
//   master - the CPU and engines side (drives requests, index, fins)
//   slave  - the dispatcher (drives dones, starts, eng_index)
interface accel_dispatch_if
  import accel_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) ();

  logic             H_int;
  logic             E_int;
  logic             D_int;
  logic [IDX_W-1:0] index;
  logic             H_done;
  logic             E_done;
  logic             D_done;
  logic             h_start;
  logic             e_start;
  logic             d_start;
  logic [IDX_W-1:0] eng_index;
  logic             h_fin;
  logic             e_fin;
  logic             d_fin;

  modport master (
    output H_int, E_int, D_int, index, h_fin, e_fin, d_fin,
    input  H_done, E_done, D_done, h_start, e_start, d_start, eng_index
  );

  modport slave (
    input  H_int, E_int, D_int, index, h_fin, e_fin, d_fin,
    output H_done, E_done, D_done, h_start, e_start, d_start, eng_index
  );

endinterface

// File: rtl/accel_watchdog.sv
// accel_watchdog: cycle counter bounding how long the dispatcher waits for
// an engine finish.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous reset of the count
//   enable     - count this cycle
//   expired    - high during the TIMEOUT-th enabled cycle after a clear
module accel_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/accel_dispatch.sv
// accel_dispatch: accepts CPU hash/encrypt/decrypt requests, pulses the
// matching engine start, waits for its finish (or a watchdog timeout) and
// returns a one-cycle done pulse to the CPU.
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - request/done and engine start/fin/index signals
//   busy         - FSM not in IDLE
//   err_timeout  - sticky: an operation completed by watchdog
//   err_multi    - sticky: more than one request high at accept
//   err_spurious - sticky: unexpected engine finish seen
//   op_count     - completed operations, wrapping
module accel_dispatch
  import accel_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  accel_dispatch_if.slave      bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_multi,
  output logic                 err_spurious,
  output logic [CNT_W-1:0]     op_count
);

  state_t           stateR, stateNext;
  op_t              opR, opNext;
  logic [IDX_W-1:0] indexR, indexNext;
  logic [2:0]       startR, startNext;
  logic [2:0]       doneR, doneNext;
  logic [CNT_W-1:0] countR, countNext;
  logic             errTimeoutR, errTimeoutNext;
  logic             errMultiR, errMultiNext;
  logic             errSpuriousR, errSpuriousNext;
  logic             busyR, busyNext;
  logic             wdClear, wdEnable, wdExpired;
  logic [2:0]       reqs, fins, selMask;

  assign reqs = {bus.H_int, bus.E_int, bus.D_int};
  assign fins = {bus.h_fin, bus.e_fin, bus.d_fin};

  accel_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wdClear),
    .enable (wdEnable),
    .expired(wdExpired)
  );

  // Outputs are computed one step ahead from the next state and registered
  // alongside it, so each pulse lines up with the state it belongs to.
  always_comb begin
    stateNext       = stateR;
    opNext          = opR;
    indexNext       = indexR;
    startNext       = '0;
    doneNext        = '0;
    countNext       = countR;
    errTimeoutNext  = errTimeoutR;
    errMultiNext    = errMultiR;
    errSpuriousNext = errSpuriousR;
    wdClear         = 1'b0;
    wdEnable        = 1'b0;
    selMask         = opMask(opR);

    if (stateR == WAIT) begin
      if ((fins & ~selMask) != 3'b000) errSpuriousNext = 1'b1;
    end else if (fins != 3'b000) begin
      errSpuriousNext = 1'b1;
    end

    unique case (stateR)
      IDLE: begin
        if (reqs != 3'b000) begin
          opNext    = reqs[2] ? OP_H : (reqs[1] ? OP_E : OP_D);
          indexNext = bus.index;
          if (multiHot(reqs)) errMultiNext = 1'b1;
          startNext = opMask(opNext);
          stateNext = START;
        end
      end
      START: begin
        wdClear   = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        wdEnable = 1'b1;
        // A finish on the expiry cycle takes precedence over the timeout.
        if ((fins & selMask) != 3'b000) begin
          doneNext  = selMask;
          countNext = countR + CNT_W'(1);
          stateNext = DONE;
        end else if (wdExpired) begin
          errTimeoutNext = 1'b1;
          doneNext       = selMask;
          countNext      = countR + CNT_W'(1);
          stateNext      = DONE;
        end
      end
      DONE: begin
        stateNext = REARM;
      end
      REARM: begin
        if (reqs == 3'b000) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR       <= IDLE;
      opR          <= OP_NONE;
      indexR       <= '0;
      startR       <= '0;
      doneR        <= '0;
      countR       <= '0;
      errTimeoutR  <= 1'b0;
      errMultiR    <= 1'b0;
      errSpuriousR <= 1'b0;
      busyR        <= 1'b0;
    end else begin
      stateR       <= stateNext;
      opR          <= opNext;
      indexR       <= indexNext;
      startR       <= startNext;
      doneR        <= doneNext;
      countR       <= countNext;
      errTimeoutR  <= errTimeoutNext;
      errMultiR    <= errMultiNext;
      errSpuriousR <= errSpuriousNext;
      busyR        <= busyNext;
    end
  end

  assign bus.h_start   = startR[2];
  assign bus.e_start   = startR[1];
  assign bus.d_start   = startR[0];
  assign bus.H_done    = doneR[2];
  assign bus.E_done    = doneR[1];
  assign bus.D_done    = doneR[0];
  assign bus.eng_index = indexR;
  assign busy          = busyR;
  assign err_timeout   = errTimeoutR;
  assign err_multi     = errMultiR;
  assign err_spurious  = errSpuriousR;
  assign op_count      = countR;

endmodule

// File: tb/tb_accel_dispatch.sv
// tb_accel_dispatch: scoreboard bench for accel_dispatch. Expected start
// and done pulses are queued as requests are driven and popped by a
// monitor when the dispatcher pulses them; directed checks cover latency,
// error flags, REARM blocking and reset behaviour.
module tb_accel_dispatch;
  import accel_pkg::*;

  localparam int IDX_W   = 11;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accel_dispatch_if #(.IDX_W(IDX_W)) bus ();

  logic             busy, errT, errM, errS;
  logic [CNT_W-1:0] opCount;

  accel_dispatch #(
    .IDX_W  (IDX_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (errT),
    .err_multi   (errM),
    .err_spurious(errS),
    .op_count    (opCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]       mask;
    logic [IDX_W-1:0] idx;
  } startExp_t;

  startExp_t  startQ[$];
  logic [2:0] doneQ[$];

  logic [2:0] startV, doneV;
  assign startV = {bus.h_start, bus.e_start, bus.d_start};
  assign doneV  = {bus.H_done, bus.E_done, bus.D_done};

  task automatic expectOp(input logic [2:0] mask, input logic [IDX_W-1:0] idx, input bit withDone);
    startExp_t e;
    e.mask = mask;
    e.idx  = idx;
    startQ.push_back(e);
    if (withDone) doneQ.push_back(mask);
  endtask

  // Waits (bounded) for a start or done pulse and checks the cycle count.
  task automatic waitSig(input string tag, input bit wantDone, input int expCycles);
    int n = 0;
    while ((((wantDone ? doneV : startV)) == 3'b000) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    checkVal(tag, 32'(n), 32'(expCycles));
  endtask

  // Scoreboard monitor.
  initial begin
    logic [2:0] prevS, prevD, expD;
    startExp_t  e;
    prevS = '0;
    prevD = '0;
    forever begin
      @(negedge clk);
      if (startV != 3'b000) begin
        checkVal("startWidth", 32'(prevS), 32'd0);
        if (startQ.size() == 0) begin
          checkVal("unexpStart", 32'(startV), 32'd0);
        end else begin
          e = startQ.pop_front();
          checkVal("startSel", 32'(startV), 32'(e.mask));
          checkVal("engIndex", 32'(bus.eng_index), 32'(e.idx));
        end
      end
      if (doneV != 3'b000) begin
        checkVal("doneWidth", 32'(prevD), 32'd0);
        if (doneQ.size() == 0) begin
          checkVal("unexpDone", 32'(doneV), 32'd0);
        end else begin
          expD = doneQ.pop_front();
          checkVal("doneSel", 32'(doneV), 32'(expD));
        end
      end
      prevS = startV;
      prevD = doneV;
    end
  end

  initial begin
    #100000;
    $display("FAIL globalTimeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n     = 1'b0;
    bus.H_int = 1'b0;
    bus.E_int = 1'b0;
    bus.D_int = 1'b0;
    bus.index = '0;
    bus.h_fin = 1'b0;
    bus.e_fin = 1'b0;
    bus.d_fin = 1'b0;
    repeat (3) @(negedge clk);

    checkVal("rstBusy",   32'(busy), 32'd0);
    checkVal("rstCount",  32'(opCount), 32'd0);
    checkVal("rstErrs",   32'({errT, errM, errS}), 32'd0);
    checkVal("rstStart",  32'(startV), 32'd0);
    checkVal("rstDone",   32'(doneV), 32'd0);
    checkVal("rstIndex",  32'(bus.eng_index), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single encrypt op, finish 5 cycles after start.
    expectOp(3'b010, 11'h2A5, 1'b1);
    bus.E_int = 1'b1;
    bus.index = 11'h2A5;
    waitSig("t1StartLat", 1'b0, 1);
    repeat (5) @(negedge clk);
    bus.e_fin = 1'b1;
    @(negedge clk);
    bus.e_fin = 1'b0;
    checkVal("t1Done", 32'(bus.E_done), 32'd1);
    bus.E_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t1Busy",  32'(busy), 32'd0);
    checkVal("t1Count", 32'(opCount), 32'd1);
    checkVal("t1Errs",  32'({errT, errM, errS}), 32'd0);

    // H and D together: H wins, err_multi; minimum 3-cycle latency.
    expectOp(3'b100, 11'h001, 1'b1);
    bus.H_int = 1'b1;
    bus.D_int = 1'b1;
    bus.index = 11'h001;
    waitSig("t2StartLat", 1'b0, 1);
    @(negedge clk);
    bus.h_fin = 1'b1;
    @(negedge clk);
    bus.h_fin = 1'b0;
    checkVal("t2Done",  32'(bus.H_done), 32'd1);
    checkVal("t2Multi", 32'(errM), 32'd1);
    bus.H_int = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("t2Rearm", 32'(busy), 32'd1);
    bus.D_int = 1'b0;
    @(negedge clk);
    checkVal("t2Idle", 32'(busy), 32'd0);
    expectOp(3'b001, 11'h001, 1'b1);
    bus.D_int = 1'b1;
    waitSig("t2DStartLat", 1'b0, 1);
    repeat (2) @(negedge clk);
    bus.d_fin = 1'b1;
    @(negedge clk);
    bus.d_fin = 1'b0;
    checkVal("t2DDone", 32'(bus.D_done), 32'd1);
    bus.D_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t2Count", 32'(opCount), 32'd3);
    checkVal("t2ErrTS", 32'({errT, errS}), 32'd0);

    // Finish on the same cycle the watchdog expires: finish wins.
    expectOp(3'b010, 11'h0F0, 1'b1);
    bus.E_int = 1'b1;
    bus.index = 11'h0F0;
    waitSig("tcStartLat", 1'b0, 1);
    repeat (TIMEOUT) @(negedge clk);
    bus.e_fin = 1'b1;
    @(negedge clk);
    bus.e_fin = 1'b0;
    checkVal("tcDone",      32'(bus.E_done), 32'd1);
    checkVal("tcNoTimeout", 32'(errT), 32'd0);
    bus.E_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("tcCount", 32'(opCount), 32'd4);

    // Decrypt with no finish: timeout after TIMEOUT WAIT cycles.
    expectOp(3'b001, 11'h3FF, 1'b1);
    bus.D_int = 1'b1;
    bus.index = 11'h3FF;
    waitSig("t3StartLat", 1'b0, 1);
    waitSig("t3DoneLat", 1'b1, TIMEOUT + 1);
    checkVal("t3Timeout", 32'(errT), 32'd1);
    bus.D_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t3Count", 32'(opCount), 32'd5);
    checkVal("t3Busy",  32'(busy), 32'd0);

    // Request held after done: no restart until it drops.
    expectOp(3'b100, 11'h123, 1'b1);
    bus.H_int = 1'b1;
    bus.index = 11'h123;
    waitSig("t4StartLat", 1'b0, 1);
    @(negedge clk);
    bus.h_fin = 1'b1;
    @(negedge clk);
    bus.h_fin = 1'b0;
    checkVal("t4Done", 32'(bus.H_done), 32'd1);
    repeat (4) @(negedge clk);
    checkVal("t4Held",    32'(busy), 32'd1);
    checkVal("t4NoStart", 32'(startV), 32'd0);
    bus.H_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t4Idle",  32'(busy), 32'd0);
    checkVal("t4Count", 32'(opCount), 32'd6);

    // Wrong-engine finish during a decrypt op.
    checkVal("t5SpurPre", 32'(errS), 32'd0);
    expectOp(3'b001, 11'h055, 1'b1);
    bus.D_int = 1'b1;
    bus.index = 11'h055;
    waitSig("t5StartLat", 1'b0, 1);
    @(negedge clk);
    bus.h_fin = 1'b1;
    @(negedge clk);
    bus.h_fin = 1'b0;
    checkVal("t5Spur",   32'(errS), 32'd1);
    checkVal("t5Busy",   32'(busy), 32'd1);
    checkVal("t5NoDone", 32'(doneV), 32'd0);
    bus.d_fin = 1'b1;
    @(negedge clk);
    bus.d_fin = 1'b0;
    checkVal("t5Done", 32'(bus.D_done), 32'd1);
    bus.D_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t5Count", 32'(opCount), 32'd7);

    // Reset during WAIT: everything clears immediately, no done.
    expectOp(3'b010, 11'h2AA, 1'b0);
    bus.E_int = 1'b1;
    bus.index = 11'h2AA;
    waitSig("t6StartLat", 1'b0, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("t6Busy",  32'(busy), 32'd0);
    checkVal("t6Count", 32'(opCount), 32'd0);
    checkVal("t6Errs",  32'({errT, errM, errS}), 32'd0);
    checkVal("t6Out",   32'({startV, doneV}), 32'd0);
    checkVal("t6Index", 32'(bus.eng_index), 32'd0);
    bus.E_int = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expectOp(3'b010, 11'h2AA, 1'b1);
    bus.E_int = 1'b1;
    waitSig("t6ReStartLat", 1'b0, 1);
    @(negedge clk);
    bus.e_fin = 1'b1;
    @(negedge clk);
    bus.e_fin = 1'b0;
    checkVal("t6Done", 32'(bus.E_done), 32'd1);
    bus.E_int = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("t6CountAfter", 32'(opCount), 32'd1);

    // Finish while IDLE.
    checkVal("t7SpurPre", 32'(errS), 32'd0);
    bus.e_fin = 1'b1;
    @(negedge clk);
    bus.e_fin = 1'b0;
    @(negedge clk);
    checkVal("t7Spur",  32'(errS), 32'd1);
    checkVal("t7Busy",  32'(busy), 32'd0);
    checkVal("t7Count", 32'(opCount), 32'd1);

    checkVal("startQEmpty", 32'(startQ.size()), 32'd0);
    checkVal("doneQEmpty",  32'(doneQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
